mat_cache_loader: RTL and testbench
===================================

Name: mat_cache_loader

Overview:
- Upstream sequencer for the matrix cache write port.
- Accepts one load command: target cache slot(s) plus layout mode.
- Consumes WIDTH vectors from a valid/ready stream and emits one registered cache write (write_op, addr1, addr2, param, data) per accepted vector, with param auto-incremented.
- Loads a whole WIDTH x WIDTH matrix by rows, by columns, or as skewed diagonals split across two slots.

Parameters:
WIDTH, 128, vector length and matrix dimension
WIDTH_ADDR_SIZE, $clog2(WIDTH), width of write_param
CACHE_SIZE, 4, number of cache slots
CACHE_ADDR_SIZE, $clog2(CACHE_SIZE), width of cache slot addresses

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  load command valid
cmd_ready  out  1  high only in IDLE
cmd_mode  in  2  0=ROW, 1=COL, 2=DIAG, 3=illegal
cmd_addr1  in  CACHE_ADDR_SIZE  primary slot
cmd_addr2  in  CACHE_ADDR_SIZE  secondary slot (DIAG only)
in_valid  in  1  input vector valid
in_ready  out  1  high only in STREAM
in_data  in  shortreal[WIDTH]  input vector
write_op  out  MatCacheWriteOp_t  cache write opcode
write_addr1  out  CACHE_ADDR_SIZE  to cache
write_addr2  out  CACHE_ADDR_SIZE  to cache
write_param  out  WIDTH_ADDR_SIZE  row, column or diagonal index
data_out  out  shortreal[WIDTH]  to cache data_in
busy  out  1  high when not in IDLE
done  out  1  one-cycle completion pulse
error  out  1  valid only with done; 1 = illegal mode

Behaviour:
- Reset values:
  - State IDLE, write_op=MAT_CACHE_WRITE_DISABLE.
  - write_addr1/write_addr2/write_param=0, data_out all 0.0.
  - done=0, error=0, busy=0, beat counter=0.
  - Reset mid-STREAM aborts at once: no further writes, no done pulse, partially written slot contents left as-is.
- States: IDLE, STREAM, FINISH (plus XPOSE, see Optional Feature).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch mode and both addresses and clear the beat counter.
  - Mode 0-2 -> STREAM. Mode 3 -> FINISH with error latched to 1.
- STREAM:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready, on the next edge register:
    - write_op = ROW / COL / DIAG opcode for the latched mode.
    - write_param = beat counter.
    - data_out = in_data.
    - write_addr1/2 = latched addresses.
  - Then increment the counter.
  - Cycles without a handshake register write_op=DISABLE (no write). Bubbles are legal and insert no write.
  - Handshake at counter==WIDTH-1 -> FINISH. The counter never wraps into a 2nd pass.
- DIAG mode:
  - Beat k writes diagonal k into addr1 (elements i<=k) and diagonal WIDTH+k into addr2 (elements i>k) in a single cache write.
  - addr1==addr2 is legal; the cache gives addr1 priority.
- FINISH:
  - write_op=DISABLE, done=1 for exactly one cycle, error as latched.
  - Next state IDLE; error cleared.
- Timing:
  - Latency from input handshake to write_op on the port: 1 cycle. The cache commits on the following edge.
  - Throughput: 1 vector/cycle.
  - Full load: WIDTH stream cycles + 1 FINISH cycle.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- in_valid outside STREAM is ignored (in_ready=0).
- A new command can be accepted in the cycle after done.
- write_op is only ever DISABLE, ROW, COL, DIAG, or TRANSPOSE (feature on).

Optional Feature:
- Macro: MAT_CACHE_LOADER_TRANSPOSE_EN.
- With the macro:
  - cmd_mode uses a 3rd bit (port widens to 3). Bit 2 = transpose-after-load.
  - When bit 2 is set, the last beat goes to XPOSE instead of FINISH.
  - XPOSE drives write_op=MAT_CACHE_WRITE_TRANSPOSE with write_addr1=latched addr1 for exactly one cycle, then goes to FINISH.
  - done is delayed by 1 cycle.
  - Illegal mode 3 skips XPOSE.
- Without the macro:
  - cmd_mode is 2 bits, no XPOSE state.
  - TRANSPOSE is never emitted.

Test Plan:
- WIDTH=4, reset then idle 3 cycles -> write_op=DISABLE, cmd_ready=1, busy=0, done=0 throughout.
- ROW load of slot 2: vectors {1,2,3,4}..{13,14,15,16}, back-to-back -> write_op=ROW with params 0,1,2,3 on cycles 1-4 after the first handshake, write_addr1=2, done at cycle 5; slot 2 reads back row1={5,6,7,8}.
- COL load of slot 1 with in_valid deasserted every other cycle -> exactly 4 COL writes with params 0..3, DISABLE on bubble cycles; slot 1 column 3 = 4th vector.
- DIAG load with addr1=0, addr2=3 and vectors all equal to k+1 on beat k -> slot0[i][j]=i+j+1 for i+j<=3; slot3[i][j]=i+j-3 for i+j>=4.
- cmd_mode=3 -> no write cycles, done=1 with error=1 one cycle after acceptance, cmd_ready back the cycle after.
- Reset asserted after 2 of 4 beats -> write_op=DISABLE the next cycle, done never pulses, cmd_ready=1. With TRANSPOSE_EN: ROW+transpose emits one TRANSPOSE after beat 4, then done.

Source files
------------

// File: rtl/mat_cache_loader.sv
// mat_cache_loader: streams one WIDTH x WIDTH matrix (rows, columns or split diagonals) into the matrix cache write port.
// Optional MAT_CACHE_LOADER_TRANSPOSE_EN adds cmd_mode bit 2: issue one TRANSPOSE write after the last beat.
package mat_cache_pkg;
   typedef enum logic [2:0] {
      MAT_CACHE_WRITE_DISABLE   = 3'd0,
      MAT_CACHE_WRITE_ROW       = 3'd1,
      MAT_CACHE_WRITE_COL       = 3'd2,
      MAT_CACHE_WRITE_DIAG      = 3'd3,
      MAT_CACHE_WRITE_TRANSPOSE = 3'd4
   } MatCacheWriteOp_t;
endpackage

module mat_cache_loader
   import mat_cache_pkg::*;
#(
   parameter int WIDTH           = 128,
   parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH),
   parameter int CACHE_SIZE      = 4,
   parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
   input  logic [2:0]                 cmd_mode,
`else
   input  logic [1:0]                 cmd_mode,
`endif
   input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
   input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0][31:0]     in_data,
   output MatCacheWriteOp_t           write_op,
   output logic [CACHE_ADDR_SIZE-1:0] write_addr1,
   output logic [CACHE_ADDR_SIZE-1:0] write_addr2,
   output logic [WIDTH_ADDR_SIZE-1:0] write_param,
   output logic [WIDTH-1:0][31:0]     data_out,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_FINISH = 2'd2
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
      ,S_XPOSE = 2'd3
`endif
   } state_t;

   localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_BEAT = WIDTH_ADDR_SIZE'(WIDTH - 1);

   state_t                       state_q, state_d;
   logic [1:0]                   mode_q, mode_d;
   logic                         xpose_q, xpose_d;
   logic [CACHE_ADDR_SIZE-1:0]   addr1_q, addr1_d;
   logic [CACHE_ADDR_SIZE-1:0]   addr2_q, addr2_d;
   logic [WIDTH_ADDR_SIZE-1:0]   cnt_q, cnt_d;
   logic                         err_q, err_d;

   MatCacheWriteOp_t             write_op_q, write_op_d;
   logic [CACHE_ADDR_SIZE-1:0]   write_addr1_q, write_addr1_d;
   logic [CACHE_ADDR_SIZE-1:0]   write_addr2_q, write_addr2_d;
   logic [WIDTH_ADDR_SIZE-1:0]   write_param_q, write_param_d;
   logic [WIDTH-1:0][31:0]       data_out_q, data_out_d;
   logic                         done_q, done_d;
   logic                         error_q, error_d;

   MatCacheWriteOp_t             stream_op;

   always_comb begin
      case (mode_q)
         2'd0:    stream_op = MAT_CACHE_WRITE_ROW;
         2'd1:    stream_op = MAT_CACHE_WRITE_COL;
         2'd2:    stream_op = MAT_CACHE_WRITE_DIAG;
         default: stream_op = MAT_CACHE_WRITE_DISABLE;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               state_d = (cmd_mode[1:0] == 2'd3) ? S_FINISH : S_STREAM;
            end
         end
         S_STREAM: begin
            if (in_valid && (cnt_q == LAST_BEAT)) begin
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
               state_d = xpose_q ? S_XPOSE : S_FINISH;
`else
               state_d = S_FINISH;
`endif
            end
         end
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
         S_XPOSE:  state_d = S_FINISH;
`endif
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic; every cache-facing output is registered
   always_comb begin
      mode_d        = mode_q;
      xpose_d       = xpose_q;
      addr1_d       = addr1_q;
      addr2_d       = addr2_q;
      cnt_d         = cnt_q;
      err_d         = err_q;
      write_op_d    = MAT_CACHE_WRITE_DISABLE;
      write_addr1_d = write_addr1_q;
      write_addr2_d = write_addr2_q;
      write_param_d = write_param_q;
      data_out_d    = data_out_q;
      done_d        = 1'b0;
      error_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               mode_d  = cmd_mode[1:0];
               addr1_d = cmd_addr1;
               addr2_d = cmd_addr2;
               cnt_d   = '0;
               err_d   = (cmd_mode[1:0] == 2'd3);
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
               xpose_d = cmd_mode[2];
`else
               xpose_d = 1'b0;
`endif
            end
         end
         S_STREAM: begin
            if (in_valid) begin
               write_op_d    = stream_op;
               write_addr1_d = addr1_q;
               write_addr2_d = addr2_q;
               write_param_d = cnt_q;
               data_out_d    = in_data;
               cnt_d         = cnt_q + 1'b1;
            end
         end
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
         S_XPOSE: begin
            write_op_d    = MAT_CACHE_WRITE_TRANSPOSE;
            write_addr1_d = addr1_q;
         end
`endif
         S_FINISH: begin
            done_d  = 1'b1;
            error_d = err_q;
            err_d   = 1'b0;
         end
         default: begin
            done_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         mode_q        <= 2'd0;
         xpose_q       <= 1'b0;
         addr1_q       <= '0;
         addr2_q       <= '0;
         cnt_q         <= '0;
         err_q         <= 1'b0;
         write_op_q    <= MAT_CACHE_WRITE_DISABLE;
         write_addr1_q <= '0;
         write_addr2_q <= '0;
         write_param_q <= '0;
         data_out_q    <= '0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         mode_q        <= mode_d;
         xpose_q       <= xpose_d;
         addr1_q       <= addr1_d;
         addr2_q       <= addr2_d;
         cnt_q         <= cnt_d;
         err_q         <= err_d;
         write_op_q    <= write_op_d;
         write_addr1_q <= write_addr1_d;
         write_addr2_q <= write_addr2_d;
         write_param_q <= write_param_d;
         data_out_q    <= data_out_d;
         done_q        <= done_d;
         error_q       <= error_d;
      end
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign in_ready    = (state_q == S_STREAM);
   assign busy        = (state_q != S_IDLE);
   assign write_op    = write_op_q;
   assign write_addr1 = write_addr1_q;
   assign write_addr2 = write_addr2_q;
   assign write_param = write_param_q;
   assign data_out    = data_out_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule

// File: tb/tb_mat_cache_loader.sv
// Bench for mat_cache_loader (WIDTH=4): directed load scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level expectation model.
module tb_mat_cache_loader;
   import mat_cache_pkg::*;

   localparam int WIDTH = 4;
   localparam int WAS   = 2;
   localparam int CS    = 4;
   localparam int CAS   = 2;
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
   localparam int MW = 3;
`else
   localparam int MW = 2;
`endif
   localparam int TK_XPOSE    = 1;
   localparam int TK_DONE     = 2;
   localparam int TK_DONE_ERR = 3;

   logic                   clock = 1'b0;
   logic                   reset;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic [MW-1:0]          cmd_mode;
   logic [CAS-1:0]         cmd_addr1, cmd_addr2;
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0][31:0] in_data;
   MatCacheWriteOp_t       write_op;
   logic [CAS-1:0]         write_addr1, write_addr2;
   logic [WAS-1:0]         write_param;
   logic [WIDTH-1:0][31:0] data_out;
   logic                   busy, done, error;

   always #5 clock = ~clock;

   mat_cache_loader #(
      .WIDTH(WIDTH), .WIDTH_ADDR_SIZE(WAS), .CACHE_SIZE(CS), .CACHE_ADDR_SIZE(CAS)
   ) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .write_op(write_op), .write_addr1(write_addr1), .write_addr2(write_addr2),
      .write_param(write_param), .data_out(data_out),
      .busy(busy), .done(done), .error(error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expectation model: vectors still owed by the current load, then a queue of tail events
   int                     m_left = 0;
   int                     m_k = 0;
   int                     m_tail[$];
   logic [1:0]             m_mode = '0;
   logic                   m_xp = 1'b0;
   logic [CAS-1:0]         m_a1 = '0, m_a2 = '0;

   MatCacheWriteOp_t       e_op;
   logic                   e_done, e_err;
   logic [CAS-1:0]         e_a1, e_a2;
   logic [WAS-1:0]         e_param;
   logic [WIDTH*32-1:0]    e_data;
   int                     e_chk;

   function automatic bit m_idle();
      return (m_left == 0) && (m_tail.size() == 0);
   endfunction

   function automatic MatCacheWriteOp_t op_of(input logic [1:0] m);
      case (m)
         2'd0:    return MAT_CACHE_WRITE_ROW;
         2'd1:    return MAT_CACHE_WRITE_COL;
         2'd2:    return MAT_CACHE_WRITE_DIAG;
         default: return MAT_CACHE_WRITE_DISABLE;
      endcase
   endfunction

   task automatic predict();
      int tok;
      e_op = MAT_CACHE_WRITE_DISABLE;
      e_done = 1'b0;
      e_err = 1'b0;
      e_chk = 0;
      if (reset) begin
         m_left = 0;
         m_tail.delete();
         e_a1 = '0; e_a2 = '0; e_param = '0; e_data = '0;
         e_chk = 1;
      end else if (m_idle()) begin
         if (cmd_valid) begin
            m_mode = cmd_mode[1:0];
            m_a1 = cmd_addr1;
            m_a2 = cmd_addr2;
            m_k = 0;
`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
            m_xp = cmd_mode[2];
`else
            m_xp = 1'b0;
`endif
            if (cmd_mode[1:0] == 2'd3) m_tail.push_back(TK_DONE_ERR);
            else m_left = WIDTH;
         end
      end else if (m_left > 0) begin
         if (in_valid) begin
            e_op = op_of(m_mode);
            e_a1 = m_a1; e_a2 = m_a2; e_param = WAS'(m_k); e_data = in_data;
            e_chk = 1;
            m_k++;
            m_left--;
            if (m_left == 0) begin
               if (m_xp) m_tail.push_back(TK_XPOSE);
               m_tail.push_back(TK_DONE);
            end
         end
      end else begin
         tok = m_tail.pop_front();
         if (tok == TK_XPOSE) begin
            e_op = MAT_CACHE_WRITE_TRANSPOSE;
            e_a1 = m_a1;
            e_chk = 2;
         end else begin
            e_done = 1'b1;
            e_err = (tok == TK_DONE_ERR);
         end
      end
   endtask

   // Inputs are set at the falling edge; one clock edge is consumed per call
   task automatic cycle();
      check("cmd_ready", 128'(cmd_ready), 128'(m_idle()));
      check("in_ready", 128'(in_ready), 128'(m_left > 0));
      check("busy", 128'(busy), 128'(!m_idle()));
      predict();
      @(posedge clock);
      @(negedge clock);
      check("write_op", 128'(write_op), 128'(e_op));
      check("done", 128'(done), 128'(e_done));
      check("error", 128'(error), 128'(e_err));
      if (e_chk != 0) check("write_addr1", 128'(write_addr1), 128'(e_a1));
      if (e_chk == 1) begin
         check("write_addr2", 128'(write_addr2), 128'(e_a2));
         check("write_param", 128'(write_param), 128'(e_param));
         check("data_out", 128'(data_out), 128'(e_data));
      end
   endtask

   task automatic idle_inputs();
      cmd_valid = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic send_cmd(input logic [MW-1:0] mode, input logic [CAS-1:0] a1, input logic [CAS-1:0] a2);
      cmd_valid = 1'b1;
      cmd_mode = mode;
      cmd_addr1 = a1;
      cmd_addr2 = a2;
      in_valid = 1'b0;
      cycle();
      cmd_valid = 1'b0;
   endtask

   // diag_style: every element of beat k is k+1; otherwise beat k holds 4k+1..4k+4
   task automatic feed(input bit bubbles, input bit diag_style, input int max_beats);
      int beats = 0;
      for (int g = 0; g < 64 && m_left > 0 && beats < max_beats; g++) begin
         in_valid = bubbles ? (g % 2 == 0) : 1'b1;
         for (int j = 0; j < WIDTH; j++)
            in_data[j] = diag_style ? 32'(m_k + 1) : 32'(m_k * WIDTH + j + 1);
         if (in_valid) beats++;
         cycle();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_mode = '0;
      cmd_addr1 = '0;
      cmd_addr2 = '0;
      in_valid = 1'b0;
      in_data = '0;
      @(posedge clock);
      @(negedge clock);
      cycle();
      reset = 1'b0;
      repeat (3) cycle();

      send_cmd(MW'(0), 2'd2, 2'd0);
      feed(1'b0, 1'b0, WIDTH);
      repeat (3) cycle();

      send_cmd(MW'(1), 2'd1, 2'd0);
      feed(1'b1, 1'b0, WIDTH);
      repeat (3) cycle();

      send_cmd(MW'(2), 2'd0, 2'd3);
      feed(1'b0, 1'b1, WIDTH);
      repeat (3) cycle();

      send_cmd(MW'(3), 2'd1, 2'd2);
      repeat (3) cycle();

      send_cmd(MW'(0), 2'd3, 2'd1);
      feed(1'b0, 1'b0, 2);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      repeat (4) cycle();

`ifdef MAT_CACHE_LOADER_TRANSPOSE_EN
      send_cmd(3'b100, 2'd2, 2'd0);
      feed(1'b0, 1'b0, WIDTH);
      repeat (4) cycle();
      send_cmd(3'b111, 2'd2, 2'd0);
      repeat (3) cycle();
`endif

      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 79) == 0);
         cmd_valid = ($urandom_range(0, 3) == 0);
         cmd_mode = MW'($urandom);
         cmd_addr1 = CAS'($urandom);
         cmd_addr2 = CAS'($urandom);
         in_valid = ($urandom_range(0, 9) < 7);
         for (int j = 0; j < WIDTH; j++) in_data[j] = $urandom;
         cycle();
      end
      reset = 1'b0;
      idle_inputs();
      repeat (WIDTH + 4) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
